// File: rtl/uart_frame_rx.sv
// uart_frame_rx -- UART receiver that assembles FRAME_BYTES bytes into one
// parallel frame with a valid/ready output and a second output buffer.
//
// Parameters
//   CLKS_PER_BIT  CLK_I cycles per UART bit (>= 8)
//   FRAME_BYTES   bytes per output frame (>= 1)
//   PARITY_EN     1 = a parity bit follows the data bits
//   PARITY_ODD    1 = odd parity, 0 = even (only used when PARITY_EN=1)
//
// Ports
//   CLK_I         clock, rising edge
//   RST_I         asynchronous active-high reset
//   UART_RX_I     asynchronous serial input, idle high
//   RX_READY_I    consumer accepts the frame when high with RX_VALID_O
//   RX_VALID_O    RX_DATA_O holds a complete, unconsumed frame
//   RX_DATA_O     frame, byte k at [8k+7:8k], byte 0 received first
//   FRAME_ERR_O   one-cycle pulse when a stop bit is sampled low
//   PARITY_ERR_O  one-cycle pulse on a parity mismatch
//   OVERRUN_O     one-cycle pulse when a completed frame is dropped
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 444,
  parameter int FRAME_BYTES  = 12,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     UART_RX_I,
  input  logic                     RX_READY_I,
  output logic                     RX_VALID_O,
  output logic [FRAME_BYTES*8-1:0] RX_DATA_O,
  output logic                     FRAME_ERR_O,
  output logic                     PARITY_ERR_O,
  output logic                     OVERRUN_O
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int DW = FRAME_BYTES * 8;
  localparam int IW = $clog2(DW);

  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic          PAR_EN    = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [BW-1:0]   byte_idx, byte_nxt;
  logic            par_acc, par_nxt;
  logic            perr_pend, perr_pend_nxt;
  logic            bit_wr;
  logic            ferr_set, perr_set;
  logic            frame_done, done_q;
  logic [DW-1:0]   work;
  logic [IW-1:0]   wr_idx;

  assign wr_idx = IW'({byte_idx, bit_idx});

  // Two-flop synchroniser, resets to the idle-high line level.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX_I;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      par_acc   <= 1'b0;
      perr_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      byte_idx  <= byte_nxt;
      par_acc   <= par_nxt;
      perr_pend <= perr_pend_nxt;
    end
  end

  // After the start bit is confirmed at mid-bit, every later sample falls
  // a full bit period apart, i.e. also at mid-bit.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_nxt       = bit_idx;
    byte_nxt      = byte_idx;
    par_nxt       = par_acc;
    perr_pend_nxt = perr_pend;
    bit_wr        = 1'b0;
    ferr_set      = 1'b0;
    perr_set      = 1'b0;
    frame_done    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt     = S_DATA;
            bit_nxt       = '0;
            par_nxt       = 1'b0;
            perr_pend_nxt = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          bit_wr  = 1'b1;
          par_nxt = par_acc ^ rx_s;
          if (bit_idx == 3'd7) begin
            state_nxt = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          state_nxt = S_STOP;
          if (rx_s != (par_acc ^ PAR_ODD)) begin
            perr_pend_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt  = '0;
          ferr_set = !rx_s;
          perr_set = perr_pend;
          if (!rx_s || perr_pend) begin
            byte_nxt = '0;
          end else if (byte_idx == LAST_BYTE) begin
            byte_nxt   = '0;
            frame_done = 1'b1;
          end else begin
            byte_nxt = byte_idx + BW'(1);
          end
          // Re-arm at mid-stop so a following start bit is not missed.
          state_nxt = rx_s ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Working buffer keeps filling while the output buffer is still held.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      work <= '0;
    end else if (bit_wr) begin
      work[wr_idx] <= rx_s;
    end
  end

  // Output buffer: a completed frame is taken one cycle after the final
  // stop bit; it is dropped only if the held frame is not consumed that cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      done_q       <= 1'b0;
      RX_VALID_O   <= 1'b0;
      RX_DATA_O    <= '0;
      FRAME_ERR_O  <= 1'b0;
      PARITY_ERR_O <= 1'b0;
      OVERRUN_O    <= 1'b0;
    end else begin
      done_q       <= frame_done;
      FRAME_ERR_O  <= ferr_set;
      PARITY_ERR_O <= perr_set;
      OVERRUN_O    <= 1'b0;
      if (done_q) begin
        if (!RX_VALID_O || RX_READY_I) begin
          RX_DATA_O  <= work;
          RX_VALID_O <= 1'b1;
        end else begin
          OVERRUN_O <= 1'b1;
        end
      end else if (RX_VALID_O && RX_READY_I) begin
        RX_VALID_O <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx: one instance without parity and one with even
// parity, both at 16 clocks per bit and 3-byte frames.
module tb_uart_frame_rx;

  localparam int CPB = 16;
  localparam int FB  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1, rx_p = 1'b1, rdy = 1'b0;
  logic        vld, ferr, perr, ovr;
  logic        vld_p, ferr_p, perr_p, ovr_p;
  logic [23:0] dat, dat_p;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .CLK_I(clk), .RST_I(rst), .UART_RX_I(rx), .RX_READY_I(rdy),
    .RX_VALID_O(vld), .RX_DATA_O(dat), .FRAME_ERR_O(ferr),
    .PARITY_ERR_O(perr), .OVERRUN_O(ovr)
  );

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .CLK_I(clk), .RST_I(rst), .UART_RX_I(rx_p), .RX_READY_I(rdy),
    .RX_VALID_O(vld_p), .RX_DATA_O(dat_p), .FRAME_ERR_O(ferr_p),
    .PARITY_ERR_O(perr_p), .OVERRUN_O(ovr_p)
  );

  int errors = 0;
  int checks = 0;

  // Monitor: sampled mid-cycle, where valid/ready equal what the next edge sees.
  int vld_cyc = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
  int vld_p_cyc = 0, ferr_p_cnt = 0, perr_p_cnt = 0;
  logic [23:0] got_q[$];
  logic [23:0] got_p_q[$];

  always @(negedge clk) begin
    if (vld && rdy)   got_q.push_back(dat);
    if (vld_p && rdy) got_p_q.push_back(dat_p);
    if (vld)    vld_cyc++;
    if (ferr)   ferr_cnt++;
    if (perr)   perr_cnt++;
    if (ovr)    ovr_cnt++;
    if (vld_p)  vld_p_cyc++;
    if (ferr_p) ferr_p_cnt++;
    if (perr_p) perr_p_cnt++;
  end

  // Frame-level reference model for the non-parity instance.
  int          mdl_idx = 0;
  int          mdl_ovr = 0;
  logic [23:0] mdl_acc = '0;
  logic [23:0] mdl_pend = '0;
  bit          mdl_pend_v = 0;
  logic [23:0] exp_q[$];

  task automatic model_byte(input logic [7:0] d, input bit ok);
    if (!ok) begin
      mdl_idx = 0;
    end else begin
      mdl_acc[mdl_idx*8 +: 8] = d;
      mdl_idx++;
      if (mdl_idx == FB) begin
        mdl_idx = 0;
        if (rdy)              exp_q.push_back(mdl_acc);
        else if (!mdl_pend_v) begin mdl_pend = mdl_acc; mdl_pend_v = 1; end
        else                  mdl_ovr++;
      end
    end
  endtask

  task automatic model_reset();
    mdl_idx = 0;
    mdl_pend_v = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
  endtask

  task automatic uart_byte(input bit sel, input logic [7:0] d, input bit par_en,
                           input logic par_bit, input logic stop_bit);
    set_line(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      tick(CPB);
    end
    if (par_en) begin
      set_line(sel, par_bit);
      tick(CPB);
    end
    set_line(sel, stop_bit);
    tick(CPB);
    set_line(sel, 1'b1);
    if (!sel) model_byte(d, stop_bit == 1'b1);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; rdy = 1'b0;
    model_reset();
    tick(3);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", vld); end
    checks++; if (dat !== 24'h0) begin errors++; $display("FAIL reset_data: got %h exp 000000", dat); end
    checks++; if ({ferr, perr, ovr} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {ferr, perr, ovr}); end
    checks++; if ({vld_p, dat_p} !== 25'h0) begin errors++; $display("FAIL reset_p_outputs: got %h exp 0", {vld_p, dat_p}); end
    rst = 1'b0;
    tick(10);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b exp 0", vld); end
  endtask

  task automatic test_basic();
    int v0, e0;
    got_q.delete(); exp_q.delete();
    rdy = 1'b1; v0 = vld_cyc; e0 = ferr_cnt + perr_cnt + ovr_cnt;
    uart_byte(0, 8'h11, 0, 0, 1);
    uart_byte(0, 8'h22, 0, 0, 1);
    uart_byte(0, 8'h33, 0, 0, 1);
    tick(10);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_frame%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (dat !== 24'h332211) begin errors++; $display("FAIL basic_data: got %h exp 332211", dat); end
    checks++; if (vld_cyc - v0 != 1) begin errors++; $display("FAIL basic_valid_len: got %0d exp 1", vld_cyc - v0); end
    checks++; if (ferr_cnt + perr_cnt + ovr_cnt - e0 != 0) begin errors++; $display("FAIL basic_err: got %0d exp 0", ferr_cnt + perr_cnt + ovr_cnt - e0); end
  endtask

  task automatic test_glitch();
    int e0;
    got_q.delete(); exp_q.delete();
    rdy = 1'b1; e0 = ferr_cnt + perr_cnt + ovr_cnt;
    rx = 1'b0; tick(4); rx = 1'b1; tick(30);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_no_frame: got %0d exp 0", got_q.size()); end
    uart_byte(0, 8'hA5, 0, 0, 1);
    uart_byte(0, 8'h5A, 0, 0, 1);
    uart_byte(0, 8'hFF, 0, 0, 1);
    tick(10);
    checks++; if (dat !== 24'hFF5AA5) begin errors++; $display("FAIL glitch_data: got %h exp FF5AA5", dat); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    checks++; if (ferr_cnt + perr_cnt + ovr_cnt - e0 != 0) begin errors++; $display("FAIL glitch_err: got %0d exp 0", ferr_cnt + perr_cnt + ovr_cnt - e0); end
  endtask

  task automatic test_frame_err();
    int f0, p0;
    got_q.delete(); exp_q.delete();
    rdy = 1'b1; f0 = ferr_cnt; p0 = perr_cnt;
    uart_byte(0, 8'h01, 0, 0, 0);
    tick(20);
    uart_byte(0, 8'h01, 0, 0, 1);
    uart_byte(0, 8'h02, 0, 0, 1);
    uart_byte(0, 8'h03, 0, 0, 1);
    tick(10);
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d exp 1", ferr_cnt - f0); end
    checks++; if (perr_cnt - p0 != 0) begin errors++; $display("FAIL ferr_no_perr: got %0d exp 0", perr_cnt - p0); end
    checks++; if (dat !== 24'h030201) begin errors++; $display("FAIL ferr_data: got %h exp 030201", dat); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_parity();
    int p0, v0, f0;
    logic [7:0] b [3];
    logic [23:0] exp_frame;
    got_p_q.delete();
    rdy = 1'b1; p0 = perr_p_cnt; v0 = vld_p_cyc; f0 = ferr_p_cnt;
    uart_byte(1, 8'h07, 1, 1'b0, 1);
    tick(10);
    checks++; if (perr_p_cnt - p0 != 1) begin errors++; $display("FAIL par_pulse: got %0d exp 1", perr_p_cnt - p0); end
    checks++; if (vld_p_cyc - v0 != 0) begin errors++; $display("FAIL par_no_valid: got %0d exp 0", vld_p_cyc - v0); end
    checks++; if (ferr_p_cnt - f0 != 0) begin errors++; $display("FAIL par_no_ferr: got %0d exp 0", ferr_p_cnt - f0); end
    b[0] = 8'h07; b[1] = 8'($urandom); b[2] = 8'($urandom);
    exp_frame = {b[2], b[1], b[0]};
    for (int i = 0; i < 3; i++) uart_byte(1, b[i], 1, even_par(b[i]), 1);
    tick(10);
    checks++; if (got_p_q.size() != 1) begin errors++; $display("FAIL par_good_count: got %0d exp 1", got_p_q.size()); end
    checks++; if (dat_p !== exp_frame) begin errors++; $display("FAIL par_good_data: got %h exp %h", dat_p, exp_frame); end
    checks++; if (perr_p_cnt - p0 != 1) begin errors++; $display("FAIL par_good_no_err: got %0d exp 1", perr_p_cnt - p0); end
  endtask

  task automatic test_overrun();
    int o0, m0;
    got_q.delete(); exp_q.delete();
    rdy = 1'b0; o0 = ovr_cnt; m0 = mdl_ovr;
    uart_byte(0, 8'h01, 0, 0, 1);
    uart_byte(0, 8'h02, 0, 0, 1);
    uart_byte(0, 8'h03, 0, 0, 1);
    tick(10);
    checks++; if ({vld, dat} !== {1'b1, 24'h030201}) begin errors++; $display("FAIL ovr_first_held: got %b/%h exp 1/030201", vld, dat); end
    uart_byte(0, 8'h04, 0, 0, 1);
    uart_byte(0, 8'h05, 0, 0, 1);
    uart_byte(0, 8'h06, 0, 0, 1);
    tick(10);
    checks++; if (ovr_cnt - o0 != mdl_ovr - m0) begin errors++; $display("FAIL ovr_pulses: got %0d exp %0d", ovr_cnt - o0, mdl_ovr - m0); end
    checks++; if ({vld, dat} !== {1'b1, mdl_pend}) begin errors++; $display("FAIL ovr_data_kept: got %b/%h exp 1/%h", vld, dat, mdl_pend); end
    rdy = 1'b1;
    if (mdl_pend_v) begin exp_q.push_back(mdl_pend); mdl_pend_v = 0; end
    tick(3);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_drain_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovr_drain%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b exp 0", vld); end
  endtask

  task automatic test_back_to_back();
    int v0, o0;
    got_q.delete(); exp_q.delete();
    rdy = 1'b1; v0 = vld_cyc; o0 = ovr_cnt;
    for (int i = 0; i < 6; i++) uart_byte(0, 8'($urandom), 0, 0, 1);
    tick(10);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_frame%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (vld_cyc - v0 != 2) begin errors++; $display("FAIL b2b_valid_len: got %0d exp 2", vld_cyc - v0); end
    checks++; if (ovr_cnt - o0 != 0) begin errors++; $display("FAIL b2b_ovr: got %0d exp 0", ovr_cnt - o0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    got_q.delete(); exp_q.delete();
    rdy = 1'b1;
    uart_byte(0, 8'h99, 0, 0, 1);
    d = 8'h05;
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 3; i++) begin rx = d[i]; tick(CPB); end
    rst = 1'b1;
    #1;
    checks++; if ({vld, dat} !== 25'h0) begin errors++; $display("FAIL rstmid_async: got %b/%h exp 0/000000", vld, dat); end
    tick(3);
    rx = 1'b1; rst = 1'b0;
    model_reset();
    tick(20);
    uart_byte(0, 8'hAA, 0, 0, 1);
    uart_byte(0, 8'hBB, 0, 0, 1);
    uart_byte(0, 8'hCC, 0, 0, 1);
    tick(10);
    checks++; if (dat !== 24'hCCBBAA) begin errors++; $display("FAIL rstmid_data: got %h exp CCBBAA", dat); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    int f0, nbad;
    bit ok;
    got_q.delete(); exp_q.delete();
    rdy = 1'b1; f0 = ferr_cnt; nbad = 0;
    for (int i = 0; i < 12; i++) begin
      ok = ($urandom_range(0, 3) != 0);
      if (!ok) nbad++;
      uart_byte(0, 8'($urandom), 0, 0, ok);
      tick($urandom_range(1, 20));
    end
    tick(10);
    checks++; if (ferr_cnt - f0 != nbad) begin errors++; $display("FAIL rand_ferr: got %0d exp %0d", ferr_cnt - f0, nbad); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
